// File: rtl/iir_pkg.sv
// Shared types and arithmetic helpers for the biquad bank.
package iir_pkg;

  // Coefficient slots inside one band; the order matches the MAC sequence.
  typedef enum logic [2:0] {
    B0 = 3'd0,
    B1 = 3'd1,
    B2 = 3'd2,
    A1 = 3'd3,
    A2 = 3'd4
  } coef_idx_e;

  localparam int NUM_COEFS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Clamp a signed value into the range of a signed 'width'-bit number.
  function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                             input int width);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi)      return hi;
    else if (value < lo) return lo;
    else                 return value;
  endfunction

  // Round half up, then drop 'frac' fractional bits (arithmetic shift).
  function automatic logic signed [63:0] round_shift(input logic signed [63:0] acc,
                                                     input int frac);
    return (acc + (64'sd1 <<< (frac - 1))) >>> frac;
  endfunction

endpackage

// File: rtl/iir_coef_bank.sv
// Double-buffered coefficient store: shadow is written freely, active is
// what the datapath reads, and a commit copies shadow into active either
// immediately or once the in-flight sample has finished.
module iir_coef_bank
  import iir_pkg::*;
#(
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int NUM_BANDS = 3,
  parameter int BAND_W    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [BAND_W-1:0]        wr_band,
  input  logic [2:0]               wr_idx,
  input  logic signed [COEF_W-1:0] wr_data,
  input  logic                     commit,
  input  logic                     commit_ok,
  input  logic                     apply_pending,
  input  logic [BAND_W-1:0]        rd_band,
  input  logic [2:0]               rd_idx,
  output logic signed [COEF_W-1:0] rd_data,
  output logic                     pending
);

  localparam logic signed [COEF_W-1:0] PASS = COEF_W'(1 << COEF_FRAC);

  logic signed [COEF_W-1:0] shadow      [NUM_BANDS][NUM_COEFS];
  logic signed [COEF_W-1:0] shadow_next [NUM_BANDS][NUM_COEFS];
  logic signed [COEF_W-1:0] active      [NUM_BANDS][NUM_COEFS];

  // Shadow contents including this cycle's write, so a same-cycle commit sees it.
  always_comb begin
    // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
    shadow_next = shadow;
    if (we && int'(wr_idx) < NUM_COEFS && int'(wr_band) < NUM_BANDS)
      shadow_next[wr_band][wr_idx] = wr_data;
  end

  // Combinational read of the active bank for the MAC.
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < NUM_COEFS && int'(rd_band) < NUM_BANDS)
      rd_data = active[rd_band][rd_idx];
  end

  // Shadow update, immediate or deferred commit into the active bank.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the coefficient arrays are small flop banks, so they are reset
      // explicitly to give a known passthrough filter out of reset.
      for (int b = 0; b < NUM_BANDS; b++) begin
        for (int i = 0; i < NUM_COEFS; i++) begin
          shadow[b][i] <= (i == int'(B0)) ? PASS : '0;
          active[b][i] <= (i == int'(B0)) ? PASS : '0;
        end
      end
      pending <= 1'b0;
    end else begin
      shadow <= shadow_next;
      if (commit && commit_ok) begin
        active  <= shadow_next;
        pending <= 1'b0;
      end else if (apply_pending && (pending || commit)) begin
        active  <= shadow_next;
        pending <= 1'b0;
      end else if (commit) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/iir_biquad_bank.sv
// NUM_BANDS Direct Form I biquads sharing one multiply-accumulate, all fed
// by the same input sample, with per-band outputs and a saturated mix.
module iir_biquad_bank
  import iir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int NUM_BANDS = 3,
  parameter int ACC_W     = DATA_W + COEF_W + 3,
  localparam int BAND_W   = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_valid,
  input  logic signed [DATA_W-1:0]      sample_in,
  input  logic                          coef_we,
  input  logic [BAND_W-1:0]             coef_band,
  input  logic [2:0]                    coef_idx,
  input  logic signed [COEF_W-1:0]      coef_data,
  input  logic                          coef_commit,
  output logic                          busy,
  output logic                          out_valid,
  output logic [NUM_BANDS*DATA_W-1:0]   band_out,
  output logic signed [DATA_W-1:0]      mix_out,
  output logic                          overrun
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int MIX_W  = DATA_W + $clog2(NUM_BANDS) + 1;

  state_e state, state_next;

  logic [2:0]               k;
  logic [BAND_W-1:0]        band;
  logic signed [DATA_W-1:0] x0, x1, x2;
  logic signed [DATA_W-1:0] y1     [NUM_BANDS];
  logic signed [DATA_W-1:0] y2     [NUM_BANDS];
  logic signed [DATA_W-1:0] band_r [NUM_BANDS];
  logic signed [DATA_W-1:0] mix_r;
  logic signed [ACC_W-1:0]  acc;
  logic                     out_valid_r;
  logic                     overrun_r;

  logic signed [COEF_W-1:0] coef;
  logic signed [DATA_W-1:0] operand;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  term;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [DATA_W-1:0] wb_val;
  logic signed [MIX_W-1:0]  mix_sum;
  logic signed [DATA_W-1:0] mix_val;
  logic                     last_band;
  logic                     coef_pending;

  iir_coef_bank #(
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .NUM_BANDS (NUM_BANDS),
    .BAND_W    (BAND_W)
  ) u_coef (
    .clk           (clk),
    .reset         (reset),
    .we            (coef_we),
    .wr_band       (coef_band),
    .wr_idx        (coef_idx),
    .wr_data       (coef_data),
    .commit        (coef_commit),
    .commit_ok     (state == IDLE && !sample_valid),
    .apply_pending (state == DONE),
    .rd_band       (band),
    .rd_idx        (k),
    .rd_data       (coef),
    .pending       (coef_pending)
  );

  assign last_band = (int'(band) == NUM_BANDS - 1);

  // MAC operand select and accumulate; the feedback terms are subtracted.
  always_comb begin
    operand = '0;
    case (k)
      3'd0:    operand = x0;
      3'd1:    operand = x1;
      3'd2:    operand = x2;
      3'd3:    operand = y1[band];
      3'd4:    operand = y2[band];
      default: operand = '0;
    endcase
    prod     = PROD_W'(coef) * PROD_W'(operand);
    term     = (k >= 3'd3) ? -ACC_W'(prod) : ACC_W'(prod);
    acc_next = (k == 3'd0) ? term : acc + term;
  end

  // Write-back value and the saturated mix of all band outputs.
  always_comb begin
    wb_val  = DATA_W'(sat(round_shift(64'(acc), COEF_FRAC), DATA_W));
    mix_sum = '0;
    for (int b = 0; b < NUM_BANDS; b++)
      mix_sum = mix_sum + MIX_W'(band_r[b]);
    mix_val = DATA_W'(sat(64'(mix_sum), DATA_W));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic: five MAC cycles and one write-back per band, then DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_valid) state_next = MAC;
      MAC:     if (k == 3'd4) state_next = WB;
      WB:      state_next = last_band ? DONE : MAC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: sample capture, accumulation, history update and outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      k           <= '0;
      band        <= '0;
      x0          <= '0;
      x1          <= '0;
      x2          <= '0;
      acc         <= '0;
      mix_r       <= '0;
      out_valid_r <= 1'b0;
      overrun_r   <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        y1[b]     <= '0;
        y2[b]     <= '0;
        band_r[b] <= '0;
      end
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      out_valid_r <= 1'b0;
      overrun_r   <= sample_valid && (state != IDLE);
      case (state)
        IDLE: begin
          if (sample_valid) begin
            x0   <= sample_in;
            k    <= '0;
            band <= '0;
          end
        end
        MAC: begin
          acc <= acc_next;
          k   <= (k == 3'd4) ? 3'd0 : k + 3'd1;
        end
        WB: begin
          band_r[band] <= wb_val;
          y2[band]     <= y1[band];
          y1[band]     <= wb_val;
          if (!last_band) band <= band + BAND_W'(1);
        end
        DONE: begin
          x2          <= x1;
          x1          <= x0;
          mix_r       <= mix_val;
          out_valid_r <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign out_valid = out_valid_r;
  assign overrun   = overrun_r;
  assign mix_out   = mix_r;

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band_out
    assign band_out[b*DATA_W +: DATA_W] = band_r[b];
  end

endmodule

// File: tb/tb_iir_biquad_bank.sv
// Directed bench for iir_biquad_bank: timing, passthrough, saturation,
// overrun, deferred commit, first-order impulse and mid-frame reset.
module tb_iir_biquad_bank;

  localparam int DW = 16;
  localparam int NB = 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 sample_valid = 1'b0;
  logic signed [DW-1:0] sample_in = '0;
  logic                 coef_we = 1'b0;
  logic [1:0]           coef_band = '0;
  logic [2:0]           coef_idx = '0;
  logic signed [15:0]   coef_data = '0;
  logic                 coef_commit = 1'b0;
  logic                 busy;
  logic                 out_valid;
  logic [NB*DW-1:0]     band_out;
  logic signed [DW-1:0] mix_out;
  logic                 overrun;

  iir_biquad_bank dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .coef_we      (coef_we),
    .coef_band    (coef_band),
    .coef_idx     (coef_idx),
    .coef_data    (coef_data),
    .coef_commit  (coef_commit),
    .busy         (busy),
    .out_valid    (out_valid),
    .band_out     (band_out),
    .mix_out      (mix_out),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [DW-1:0] x;
    logic signed [DW-1:0] b0, b1, b2;
    logic signed [DW-1:0] mix;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Per-frame observations.
  int ov_count, ov_cycle, ovr_count, ovr_cycle, busy_err;
  logic signed [DW-1:0] cap_b [NB];
  logic signed [DW-1:0] cap_mix;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic logic signed [DW-1:0] bo(input int b);
    return band_out[b*DW +: DW];
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wr_coef(input int band, input int idx, input int data, input logic commit);
    coef_we     = 1'b1;
    coef_band   = 2'(band);
    coef_idx    = 3'(idx);
    coef_data   = 16'(data);
    coef_commit = commit;
    @(posedge clk);
    #1;
    coef_we     = 1'b0;
    coef_commit = 1'b0;
  endtask

  // Present x in cycle 0 and observe cycles 1..24. Optional extra sample,
  // commit and reset are driven during the given cycle numbers (-1 = none).
  task automatic frame(input logic signed [DW-1:0] x, input int drop_cyc,
                       input int commit_cyc, input int reset_cyc);
    logic exp_busy;
    ov_count = 0; ov_cycle = -1; ovr_count = 0; ovr_cycle = -1; busy_err = 0;
    sample_in    = x;
    sample_valid = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      #1;
      sample_valid = 1'b0;
      coef_commit  = 1'b0;
      reset        = 1'b0;
      exp_busy = (n <= 6*NB+1) && (reset_cyc < 0 || n <= reset_cyc);
      if (busy !== exp_busy) busy_err++;
      if (out_valid) begin
        ov_count++;
        if (ov_cycle < 0) begin
          ov_cycle = n;
          for (int b = 0; b < NB; b++) cap_b[b] = bo(b);
          cap_mix = mix_out;
        end
      end
      if (overrun) begin
        ovr_count++;
        if (ovr_cycle < 0) ovr_cycle = n;
      end
      if (n == drop_cyc)   begin sample_valid = 1'b1; sample_in = x + 16'sd777; end
      if (n == commit_cyc) coef_commit = 1'b1;
      if (n == reset_cyc)  reset = 1'b1;
    end
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    check({tag, " out_valid count"}, ov_count, 1);
    check({tag, " out_valid cycle"}, ov_cycle, 20);
    check({tag, " busy profile errors"}, busy_err, 0);
    check({tag, " band0"}, cap_b[0], v.b0);
    check({tag, " band1"}, cap_b[1], v.b1);
    check({tag, " band2"}, cap_b[2], v.b2);
    check({tag, " mix"}, cap_mix, v.mix);
  endtask

  vec_t sat_tab [7];
  vec_t imp_tab [3];

  initial begin
    // Passthrough bank: y = x in every band, mix saturates at 16 bits.
    sat_tab[0] = '{x:  16'sd30000, b0:  16'sd30000, b1:  16'sd30000, b2:  16'sd30000, mix:  16'sd32767};
    sat_tab[1] = '{x: -16'sd30000, b0: -16'sd30000, b1: -16'sd30000, b2: -16'sd30000, mix: -16'sd32768};
    sat_tab[2] = '{x:  16'sd0,     b0:  16'sd0,     b1:  16'sd0,     b2:  16'sd0,     mix:  16'sd0};
    sat_tab[3] = '{x: -16'sd1,     b0: -16'sd1,     b1: -16'sd1,     b2: -16'sd1,     mix: -16'sd3};
    sat_tab[4] = '{x:  16'sd32767, b0:  16'sd32767, b1:  16'sd32767, b2:  16'sd32767, mix:  16'sd32767};
    sat_tab[5] = '{x: -16'sd32768, b0: -16'sd32768, b1: -16'sd32768, b2: -16'sd32768, mix: -16'sd32768};
    sat_tab[6] = '{x:  16'sd5000,  b0:  16'sd5000,  b1:  16'sd5000,  b2:  16'sd5000,  mix:  16'sd15000};
    // Band0 y = x/2 + y1/2; bands 1-2 passthrough.
    imp_tab[0] = '{x: 16'sd16384, b0: 16'sd8192, b1: 16'sd16384, b2: 16'sd16384, mix: 16'sd32767};
    imp_tab[1] = '{x: 16'sd0,     b0: 16'sd4096, b1: 16'sd0,     b2: 16'sd0,     mix: 16'sd4096};
    imp_tab[2] = '{x: 16'sd0,     b0: 16'sd2048, b1: 16'sd0,     b2: 16'sd0,     mix: 16'sd2048};

    @(posedge clk);
    #1;
    do_reset();
    check("reset busy", busy, 0);
    check("reset out_valid", out_valid, 0);
    check("reset overrun", overrun, 0);
    check("reset band_out", band_out, 0);
    check("reset mix_out", mix_out, 0);

    frame(16'sd1000, -1, -1, -1);
    check_frame("passthrough", '{x: 16'sd1000, b0: 16'sd1000, b1: 16'sd1000, b2: 16'sd1000, mix: 16'sd3000});

    // Writes to slot 5 must not disturb the bank.
    wr_coef(0, 5, 0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      frame(sat_tab[i].x, -1, -1, -1);
      check_frame($sformatf("sat[%0d]", i), sat_tab[i]);
    end

    frame(16'sd1000, 5, -1, -1);
    check("overrun count", ovr_count, 1);
    check("overrun cycle", ovr_cycle, 6);
    check_frame("overrun", '{x: 16'sd1000, b0: 16'sd1000, b1: 16'sd1000, b2: 16'sd1000, mix: 16'sd3000});

    wr_coef(1, 0, 0, 1'b0);
    frame(16'sd2000, -1, 3, -1);
    check_frame("deferred old", '{x: 16'sd2000, b0: 16'sd2000, b1: 16'sd2000, b2: 16'sd2000, mix: 16'sd6000});
    frame(16'sd2000, -1, -1, -1);
    check_frame("deferred new", '{x: 16'sd2000, b0: 16'sd2000, b1: 16'sd0, b2: 16'sd2000, mix: 16'sd4000});

    do_reset();
    wr_coef(0, 0, 8192, 1'b0);
    wr_coef(0, 3, -8192, 1'b1);
    for (int i = 0; i < 3; i++) begin
      frame(imp_tab[i].x, -1, -1, -1);
      check_frame($sformatf("impulse[%0d]", i), imp_tab[i]);
    end

    frame(16'sd1000, -1, -1, 8);
    check("midreset out_valid count", ov_count, 0);
    check("midreset busy profile errors", busy_err, 0);
    check("midreset band_out", band_out, 0);
    check("midreset mix_out", mix_out, 0);
    frame(16'sd1000, -1, -1, -1);
    check_frame("after reset", '{x: 16'sd1000, b0: 16'sd1000, b1: 16'sd1000, b2: 16'sd1000, mix: 16'sd3000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
